memory_reader: RTL

MEMORY_READER -- requirements
Module: memory_reader

---
 rtl/memory_reader.sv | 108 ++++++++++
 1 files changed

// File: rtl/memory_reader.sv
// Burst memory reader: issues COUNT sequential reads starting at ADDR_IN, waits
// WAIT_CYCLES per word for the memory, and presents each captured word with a pulse.
module memory_reader #(
  parameter int ADDR_BITS   = 16,
  parameter int DATA_BITS   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [ADDR_BITS-1:0] ADDR_IN,
  input  logic [7:0]           COUNT,
  output logic [ADDR_BITS-1:0] MEM_ADDR,
  output logic                 MEM_RE,
  input  logic [DATA_BITS-1:0] MEM_DATA,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 WORD_VALID,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2:0]           STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  state_t               state, state_nx;
  logic [ADDR_BITS-1:0] addr_q, addr_nx;
  logic [DATA_BITS-1:0] data_q, data_nx;
  logic [7:0]           remaining, rem_nx;
  logic [3:0]           wait_cnt, wait_nx;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nx;
      addr_q    <= addr_nx;
      data_q    <= data_nx;
      remaining <= rem_nx;
      wait_cnt  <= wait_nx;
    end
  end

  // Inputs are only looked at in IDLE, so mid-burst START/ADDR_IN/COUNT activity is ignored.
  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    data_nx  = data_q;
    rem_nx   = remaining;
    wait_nx  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (START) begin
          if (COUNT != 8'd0) begin
            addr_nx  = ADDR_IN;
            rem_nx   = COUNT;
            state_nx = S_ISSUE;
          end else begin
            state_nx = S_FINISH;
          end
        end
      end
      S_ISSUE: begin
        wait_nx  = 4'd0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // The counter reaches WAIT_LIM on the last wait cycle, when memory data is valid.
        wait_nx = wait_cnt + 4'd1;
        if (wait_nx == WAIT_LIM) begin
          data_nx  = MEM_DATA;
          state_nx = S_NEXT;
        end
      end
      S_NEXT: begin
        rem_nx = remaining - 8'd1;
        if (remaining > 8'd1) begin
          addr_nx  = addr_q + ADDR_BITS'(1);
          state_nx = S_ISSUE;
        end else begin
          state_nx = S_FINISH;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign MEM_ADDR   = addr_q;
  assign DATA_OUT   = data_q;
  assign MEM_RE     = (state == S_ISSUE);
  assign WORD_VALID = (state == S_NEXT);
  assign DONE       = (state == S_FINISH);
  assign BUSY       = (state != S_IDLE);
  assign STATE      = state;

endmodule
